cpu_oci_trace_capture: RTL and testbench
========================================

CPU_OCI_TRACE_CAPTURE -- requirements
Module: cpu_oci_trace_capture

Interface
REQ-001 Parameter: DATA_W, default 30, width of one debug trace word.
REQ-002 Parameter: DEPTH, default 16, buffer depth in words; power of two, 2..256.
REQ-003 Parameter: WRAP_MODE, default 0; 0 = stop-when-full (drop newest), 1 = wrap (overwrite oldest).
REQ-004 Parameter: OVF_W, default 16, width of the dropped-word counter.
REQ-005 Derived: CNT_W = log2(DEPTH)+1.
REQ-006 One clock; reset is synchronous and active-high. Ports clk and reset are named as the codebase names them.
REQ-007 clk  in  1  sole clock; all state changes on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 dct_buffer  in  DATA_W  trace word offered for capture.
REQ-010 dct_valid  in  1  dct_buffer valid this cycle; no backpressure.
REQ-011 test_ending  in  1  request to stop capture and drain.
REQ-012 test_has_ended  in  1  immediate freeze.
REQ-013 rd_ready  in  1  consumer accepts rd_data this cycle.
REQ-014 rd_valid  out  1  buffer holds a readable word.
REQ-015 rd_data  out  DATA_W  oldest stored word (first-word-fall-through).
REQ-016 dct_count  out  CNT_W  current occupancy, 0..DEPTH.
REQ-017 ovf_count  out  OVF_W  words lost to full condition; saturating.
REQ-018 done  out  1  high in DONE state.

Function
REQ-019 States CAPTURE, DRAIN and DONE SHALL exist. CAPTURE is the reset state.
REQ-020 CAPTURE: write when dct_valid=1 (subject to REQ-024/025). test_ending=1 -> DRAIN next cycle; a write in that same cycle is still accepted.
REQ-021 DRAIN: dct_valid ignored, not counted as overflow. Reads continue. Transition to DONE on the cycle occupancy becomes 0, or next cycle if already 0.
REQ-022 test_has_ended=1 in any state -> DONE next cycle. It has priority over test_ending. The write in that cycle is not accepted.
REQ-023 DONE: no writes, no reads, rd_valid=0, contents and counters frozen; exit only via reset.
REQ-024 Read fires when rd_valid & rd_ready.
- rd_valid = (dct_count!=0) & state!=DONE.
- rd_data = mem[rd_ptr], combinational from the stored entry.
- Read advances rd_ptr and decrements count.
REQ-025 Write to a non-full buffer:
- Stores at wr_ptr, advances wr_ptr.
- Count increments unless a read fires in the same cycle, in which case count is unchanged.
REQ-026 Write when full (count=DEPTH) with a simultaneous read: normal write; count stays DEPTH; no overflow.
REQ-027 Write when full without a read:
- WRAP_MODE=0: word dropped, pointers unchanged, ovf_count+1.
- WRAP_MODE=1: word stored at wr_ptr, both pointers advance, count stays DEPTH, ovf_count+1.
REQ-028 Write-to-read latency: a word written at edge N is visible on rd_valid/rd_data after edge N; a read cannot occur in the write cycle when empty.
REQ-029 Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-030 ovf_count saturates at all-ones and does not wrap.

Reset
REQ-031 reset=1 at any edge, including mid-drain or in DONE:
- state=CAPTURE, pointers=0, dct_count=0, ovf_count=0.
- rd_valid=0, done=0.
- Memory contents need not be cleared.
REQ-032 reset SHALL take priority over dct_valid, rd_ready, test_ending and test_has_ended in the same cycle.

Verification
REQ-033 DEPTH=16, WRAP_MODE=0: write 0x1..0x14 (20 words), rd_ready=0 -> dct_count=16, ovf_count=4; reading yields 0x1..0x10 in order.
REQ-034 DEPTH=16, WRAP_MODE=1: same stimulus -> dct_count=16, ovf_count=4; reading yields 0x5..0x14.
REQ-035 Full buffer, dct_valid=1 and rd_ready=1 for 8 cycles -> count stays 16, ovf_count=0, output order preserved.
REQ-036 5 words stored, then test_ending pulse with rd_ready=1:
- Further dct_valid ignored.
- Exactly 5 reads occur.
- done=1 the cycle after count reaches 0.
REQ-037 3 words stored, then test_has_ended=1 and test_ending=1 together -> done=1 next cycle, rd_valid=0, dct_count=3 held; a reset pulse then yields count=0, done=0, state CAPTURE.
REQ-038 OVF_W=4, WRAP_MODE=0, full buffer, 20 dropped writes -> ovf_count=0xF, held.

Source files
------------

// File: rtl/cpu_oci_trace_capture.sv
// cpu_oci_trace_capture: on-chip debug trace buffer with a first-word-fall-through read side.
// It has two overflow policies (stop or wrap), can drain on request, and freezes when the test ends.
module cpu_oci_trace_capture #(
  parameter int DATA_W    = 30,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0,
  parameter int OVF_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        dct_buffer,
  input  logic                     dct_valid,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   dct_count,
  output logic [OVF_W-1:0]         ovf_count,
  output logic                     done
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef enum logic [1:0] {S_CAPTURE, S_DRAIN, S_DONE} state_t;
  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [OVF_W-1:0]  r_ovf;
  logic              w_full, w_rd, w_wr, w_drop, w_store, w_evict;
  always_comb begin
    w_full  = r_count == CNT_W'(DEPTH);
    w_rd    = rd_valid && rd_ready;
    w_wr    = dct_valid && r_state == S_CAPTURE && !test_has_ended;
    w_drop  = w_wr && w_full && !w_rd;
    w_store = w_wr && !(w_drop && WRAP_MODE == 0);
    w_evict = w_drop && WRAP_MODE != 0;
  end
  assign rd_valid  = r_count != '0 && r_state != S_DONE;
  assign rd_data   = r_mem[r_rd_ptr];
  assign dct_count = r_count;
  assign ovf_count = r_ovf;
  assign done      = r_state == S_DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_CAPTURE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd || w_evict) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_store && !w_rd && !w_full ? r_count + 1'b1 :
                 w_rd && !w_store ? r_count - 1'b1 : r_count;
      if (w_drop && r_ovf != '1) r_ovf <= r_ovf + 1'b1;
      // draining finishes on the edge that removes the last word
      r_state <= test_has_ended ? S_DONE :
                 r_state == S_CAPTURE && test_ending ? S_DRAIN :
                 r_state == S_DRAIN && (r_count == '0 || (w_rd && r_count == CNT_W'(1))) ? S_DONE :
                 r_state;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && w_store) r_mem[r_wr_ptr] <= dct_buffer;
  end
endmodule

// File: tb/tb_cpu_oci_trace_capture.sv
// tb_cpu_oci_trace_capture: three configurations (stop, wrap, 4-bit overflow counter) checked against a queue model.
module tb_cpu_oci_trace_capture;
  typedef logic [29:0] wq_t [$];
  logic        clk = 0, reset = 1, dct_valid = 0, test_ending = 0, test_has_ended = 0, rd_ready = 0;
  logic [29:0] dct_buffer = '0;
  logic [29:0] o_data [3];
  logic [4:0]  o_cnt [3];
  logic [15:0] o_ovf [3];
  logic        o_valid [3], o_done [3];
  logic [15:0] ovf0, ovf1;
  logic [3:0]  ovf2;
  int          n_cmp = 0, n_fail = 0;
  wq_t         mq0, mq1, mq2;
  int          mst [3], mov [3];
  always #5 clk = ~clk;
  assign o_ovf[0] = ovf0;
  assign o_ovf[1] = ovf1;
  assign o_ovf[2] = {12'd0, ovf2};
  cpu_oci_trace_capture dut0 (.clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_valid(dct_valid),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready), .rd_valid(o_valid[0]),
    .rd_data(o_data[0]), .dct_count(o_cnt[0]), .ovf_count(ovf0), .done(o_done[0]));
  cpu_oci_trace_capture #(.WRAP_MODE(1)) dut1 (.clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_valid(dct_valid),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready), .rd_valid(o_valid[1]),
    .rd_data(o_data[1]), .dct_count(o_cnt[1]), .ovf_count(ovf1), .done(o_done[1]));
  cpu_oci_trace_capture #(.OVF_W(4)) dut2 (.clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_valid(dct_valid),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready), .rd_valid(o_valid[2]),
    .rd_data(o_data[2]), .dct_count(o_cnt[2]), .ovf_count(ovf2), .done(o_done[2]));
  // reference: the buffer is a queue; st 0=capture 1=drain 2=done
  task automatic mstep(inout wq_t q, inout int st, inout int ov, input bit wrap, input int ovmax);
    bit full0, rd, wr;
    if (reset) begin
      q.delete();
      st = 0;
      ov = 0;
      return;
    end
    full0 = q.size() == 16;
    rd = q.size() != 0 && st != 2 && rd_ready;
    wr = dct_valid && st == 0 && !test_has_ended;
    if (rd) void'(q.pop_front());
    if (wr && (!full0 || rd)) q.push_back(dct_buffer);
    else if (wr) begin
      if (ov < ovmax) ov++;
      if (wrap) begin
        void'(q.pop_front());
        q.push_back(dct_buffer);
      end
    end
    if (test_has_ended) st = 2;
    else if (st == 0 && test_ending) st = 1;
    else if (st == 1 && q.size() == 0) st = 2;
  endtask
  always @(posedge clk) begin
    mstep(mq0, mst[0], mov[0], 1'b0, 65535);
    mstep(mq1, mst[1], mov[1], 1'b1, 65535);
    mstep(mq2, mst[2], mov[2], 1'b0, 15);
  end
  function automatic int msz(int k);
    return k == 0 ? mq0.size() : k == 1 ? mq1.size() : mq2.size();
  endfunction
  function automatic logic [29:0] mfr(int k);
    if (k == 0) return mq0.size() != 0 ? mq0[0] : '0;
    if (k == 1) return mq1.size() != 0 ? mq1[0] : '0;
    return mq2.size() != 0 ? mq2[0] : '0;
  endfunction
  function automatic bit mval(int k);
    return msz(k) != 0 && mst[k] != 2;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1; dct_valid = 0; rd_ready = 0; test_ending = 0; test_has_ended = 0;
    tick();
    reset = 0;
  endtask
  task automatic write_n(int n);
    for (int i = 0; i < n; i++) begin
      dct_valid = 1;
      dct_buffer = 30'($urandom);
      tick();
    end
    dct_valid = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (o_cnt[k] !== 5'd0 || o_ovf[k] !== 16'd0 || o_valid[k] !== 1'b0 || o_done[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset k=%0d cnt=%0d ovf=%0d valid=%b done=%b, want all 0", k, o_cnt[k], o_ovf[k], o_valid[k], o_done[k]);
      end
    end
  endtask
  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      dct_valid = 1;
      dct_buffer = 30'(i);
      tick();
    end
    dct_valid = 0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (o_cnt[k] !== 5'd16 || o_ovf[k] !== 16'd4) begin
        n_fail++;
        $display("FAIL fill k=%0d cnt=%0d ovf=%0d, want 16 and 4", k, o_cnt[k], o_ovf[k]);
      end
    end
    rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (o_valid[k] !== 1'b1 || o_data[k] !== 30'(k == 1 ? i + 5 : i + 1)) begin
          n_fail++;
          $display("FAIL fill_read k=%0d i=%0d valid=%b data=%h, want %h", k, i, o_valid[k], o_data[k], k == 1 ? i + 5 : i + 1);
        end
      end
      tick();
    end
    rd_ready = 0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (o_cnt[k] !== 5'd0 || o_valid[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_empty k=%0d cnt=%0d valid=%b, want 0 and 0", k, o_cnt[k], o_valid[k]);
      end
    end
  endtask
  task automatic test_full_rw();
    do_reset();
    write_n(16);
    dct_valid = 1;
    rd_ready = 1;
    for (int c = 0; c < 24; c++) begin
      if (c == 8) dct_valid = 0;
      dct_buffer = 30'($urandom);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (o_valid[k] !== mval(k) || o_data[k] !== mfr(k) || o_cnt[k] !== 5'(msz(k))) begin
          n_fail++;
          $display("FAIL full_rw k=%0d c=%0d valid=%b/%b data=%h/%h cnt=%0d/%0d", k, c, o_valid[k], mval(k), o_data[k], mfr(k), o_cnt[k], msz(k));
        end
      end
      tick();
      if (c == 7)
        for (int k = 0; k < 3; k++) begin
          n_cmp++;
          if (o_cnt[k] !== 5'd16 || o_ovf[k] !== 16'd0) begin
            n_fail++;
            $display("FAIL full_rw_hold k=%0d cnt=%0d ovf=%0d, want 16 and 0", k, o_cnt[k], o_ovf[k]);
          end
        end
    end
    rd_ready = 0;
  endtask
  task automatic test_drain();
    int nread = 0, ncyc = 0;
    do_reset();
    write_n(5);
    rd_ready = 1;
    test_ending = 1;
    for (int c = 0; c < 20 && !o_done[0]; c++) begin
      if (o_valid[0]) nread++;
      tick();
      ncyc++;
      test_ending = 0;
      dct_valid = 1;
      dct_buffer = 30'($urandom);
    end
    dct_valid = 0;
    rd_ready = 0;
    n_cmp++;
    if (nread != 5 || ncyc != 5) begin
      n_fail++;
      $display("FAIL drain reads=%0d cycles=%0d, want 5 and 5", nread, ncyc);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (o_done[k] !== 1'b1 || o_cnt[k] !== 5'd0 || o_ovf[k] !== 16'd0 || o_valid[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_end k=%0d done=%b cnt=%0d ovf=%0d valid=%b, want 1 0 0 0", k, o_done[k], o_cnt[k], o_ovf[k], o_valid[k]);
      end
    end
  endtask
  task automatic test_has_ended_freeze();
    do_reset();
    write_n(3);
    dct_valid = 1; test_has_ended = 1; test_ending = 1;
    tick();
    test_has_ended = 0; test_ending = 0; rd_ready = 1;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (o_done[k] !== 1'b1 || o_valid[k] !== 1'b0 || o_cnt[k] !== 5'd3) begin
          n_fail++;
          $display("FAIL freeze k=%0d c=%0d done=%b valid=%b cnt=%0d, want 1 0 3", k, c, o_done[k], o_valid[k], o_cnt[k]);
        end
      end
      dct_buffer = 30'($urandom);
      tick();
    end
    reset = 1; test_has_ended = 1; test_ending = 1;
    tick();
    reset = 0; test_has_ended = 0; test_ending = 0; rd_ready = 0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (o_done[k] !== 1'b0 || o_cnt[k] !== 5'd0 || o_valid[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_reset k=%0d done=%b cnt=%0d valid=%b, want 0 0 0", k, o_done[k], o_cnt[k], o_valid[k]);
      end
    end
    dct_buffer = 30'h2aaa_5555;
    tick();
    dct_valid = 0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (o_cnt[k] !== 5'd1 || o_data[k] !== 30'h2aaa_5555) begin
        n_fail++;
        $display("FAIL freeze_recapture k=%0d cnt=%0d data=%h, want 1 and 2aaa5555", k, o_cnt[k], o_data[k]);
      end
    end
  endtask
  task automatic test_ovf_saturate();
    do_reset();
    write_n(36);
    n_cmp++;
    if (o_ovf[2] !== 16'hF || o_ovf[0] !== 16'd20 || o_ovf[1] !== 16'd20) begin
      n_fail++;
      $display("FAIL ovf_sat ovf=%0d/%0d/%0d, want 20/20/15", o_ovf[0], o_ovf[1], o_ovf[2]);
    end
    tick();
    write_n(5);
    n_cmp++;
    if (o_ovf[2] !== 16'hF || o_ovf[0] !== 16'd25 || o_cnt[2] !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_hold ovf2=%0d ovf0=%0d cnt2=%0d, want 15 25 16", o_ovf[2], o_ovf[0], o_cnt[2]);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      reset = $urandom_range(199) == 0;
      dct_valid = $urandom_range(3) != 0;
      dct_buffer = 30'($urandom);
      rd_ready = $urandom_range(2) == 0;
      test_ending = $urandom_range(79) == 0;
      test_has_ended = $urandom_range(149) == 0;
      tick();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (o_cnt[k] !== 5'(msz(k)) || o_ovf[k] !== 16'(mov[k]) || o_done[k] !== (mst[k] == 2) ||
            o_valid[k] !== mval(k) || (mval(k) && o_data[k] !== mfr(k))) begin
          n_fail++;
          $display("FAIL random k=%0d c=%0d cnt=%0d/%0d ovf=%0d/%0d done=%b/%0d valid=%b/%b data=%h/%h",
                   k, c, o_cnt[k], msz(k), o_ovf[k], mov[k], o_done[k], mst[k] == 2, o_valid[k], mval(k), o_data[k], mfr(k));
        end
      end
    end
    reset = 0; dct_valid = 0; rd_ready = 0; test_ending = 0; test_has_ended = 0;
  endtask
  initial begin
    test_reset();
    test_fill_overflow();
    test_full_rw();
    test_drain();
    test_has_ended_freeze();
    test_ovf_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
